// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side controller for the synchronous FIFO.
// Issues FIFO reads under a 2-credit scheme, captures the returned words into a
// 2-entry output buffer and presents them as a valid/ready stream grouped into
// bursts of burst_len words, with out_last on the final word of each burst.
// Optional feature: define FIFO_BURST_READER_STATS_EN to add a completed-burst
// counter (burst_count) with a synchronous clear (stats_clr).
module fifo_burst_reader #(
  parameter int unsigned width     = 16,
  parameter int unsigned burst_len = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             rd_en,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_data_out,
  output logic             fifo_read,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last,
`ifdef FIFO_BURST_READER_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      burst_count,
`endif
  output logic             busy
);

  localparam logic [7:0] LastCount = 8'(burst_len - 1);

  typedef enum logic [1:0] {StIdle, StActive, StStopping, StDrain} state_e;

  state_e           state_q, state_d;
  logic [7:0]       count_q, count_d;
  logic             inflight_q, inflight_last_q;
  logic [1:0]       occ_q, occ_d;
  logic [width-1:0] buf_data_q [2];
  logic             buf_last_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic             active, credit, issue_last, push, pop;

  // Credit uses registered occupancy only; a same-cycle pop does not free a slot.
  assign active     = (state_q == StActive) || (state_q == StStopping);
  assign credit     = (occ_q == 2'd0) || ((occ_q == 2'd1) && !inflight_q);
  assign fifo_read  = active && !fifo_empty && credit;
  assign issue_last = (count_q == LastCount);
  assign push       = inflight_q;
  assign out_valid  = (occ_q != 2'd0);
  assign pop        = out_valid && out_ready;
  assign out_data   = buf_data_q[rd_ptr_q];
  assign out_last   = buf_last_q[rd_ptr_q];
  assign busy       = (state_q != StIdle);

  // Next burst position and buffer occupancy.
  always_comb begin
    count_d = count_q;
    if (fifo_read) begin
      count_d = issue_last ? 8'd0 : count_q + 8'd1;
    end
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!push && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  // FSM next-state: stopping only ever happens on a burst boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (rd_en) state_d = StActive;
      end
      StActive: begin
        // count_d accounts for a read issued this cycle.
        if (!rd_en) state_d = (count_d == 8'd0) ? StDrain : StStopping;
      end
      StStopping: begin
        if (rd_en) begin
          state_d = StActive;
        end else if (fifo_read && issue_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (rd_en) begin
          state_d = StActive;
        end else if (!inflight_q && (occ_q == 2'd0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state: FSM, burst counter, in-flight read tracking, occupancy.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q         <= StIdle;
      count_q         <= 8'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      inflight_q      <= fifo_read;
      inflight_last_q <= fifo_read && issue_last;
      occ_q           <= occ_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Output buffer storage; the last tag travels with the word from issue time.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
    end else if (push) begin
      buf_data_q[wr_ptr_q] <= fifo_data_out;
      buf_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  logic [15:0] burst_count_q;

  // Count accepted last words; clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      burst_count_q <= 16'd0;
    end else if (stats_clr) begin
      burst_count_q <= 16'd0;
    end else if (pop && out_last) begin
      burst_count_q <= burst_count_q + 16'd1;
    end
  end

  assign burst_count = burst_count_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader (burst_len = 4, width = 16).
// A queue-backed FIFO model feeds the DUT; expected words are queued when
// written into the model and compared when the DUT hands them over.
module tb_fifo_burst_reader;

  localparam int BL = 4;

  logic        clk;
  logic        rst_;
  logic        rd_en;
  logic        fifo_empty;
  logic [15:0] fifo_data_out;
  logic        fifo_read;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
`ifdef FIFO_BURST_READER_STATS_EN
  logic        stats_clr;
  logic [15:0] burst_count;
`endif

  fifo_burst_reader #(
    .width    (16),
    .burst_len(BL)
  ) dut (
    .clk          (clk),
    .rst_         (rst_),
    .rd_en        (rd_en),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_read    (fifo_read),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
`ifdef FIFO_BURST_READER_STATS_EN
    .stats_clr    (stats_clr),
    .burst_count  (burst_count),
`endif
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model
  logic [15:0] mem [128];
  int          wr_idx = 0;
  int          rd_idx = 0;
  int          rd_total = 0;
  int          rd_empty_err = 0;
  assign fifo_empty = (rd_idx == wr_idx);

  // Scoreboard
  logic [15:0] exp_q [$];
  logic [15:0] exp_word;
  int          acc_cnt = 0;
  int          acc_total = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    mem[wr_idx] = d;
    wr_idx++;
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    rd_en = 1'b0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  // FIFO read side: data appears the cycle after fifo_read.
  always @(posedge clk) begin
    if (fifo_read) begin
      if (rd_idx == wr_idx) begin
        rd_empty_err <= rd_empty_err + 1;
      end else begin
        fifo_data_out <= mem[rd_idx];
        rd_idx        <= rd_idx + 1;
        rd_total      <= rd_total + 1;
      end
    end
  end

  // Output monitor, sampled between active edges.
  always @(negedge clk) begin
    if (rst_ && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", 1, 0);
      end else begin
        exp_word = exp_q.pop_front();
        check("data", out_data, exp_word);
        check("last", out_last, ((acc_cnt % BL) == BL - 1));
        acc_cnt++;
        acc_total++;
      end
    end
  end

  int snap_rd;
  int snap_acc;
  int n;

  initial begin
    rst_          = 1'b0;
    rd_en         = 1'b0;
    out_ready     = 1'b0;
    fifo_data_out = 16'h0;
`ifdef FIFO_BURST_READER_STATS_EN
    stats_clr     = 1'b0;
`endif
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
`ifdef FIFO_BURST_READER_STATS_EN
    check("rst_burst_count", burst_count, 0);
`endif
    tick();
    rst_ = 1'b1;
    tick();

    // Single burst
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    out_ready = 1'b1;
    rd_en     = 1'b1;
    check("idle_no_read", fifo_read, 0);
    tick();
    check("first_read", fifo_read, 1);
    check("busy_active", busy, 1);
    wait_drain(40);
    wait_idle(20);

    // Back-pressure
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    snap_rd = rd_total;
    rd_en   = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("stall_reads", rd_total - snap_rd, 2);
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 16'h0001);
    tick();
    check("stall_data_hold", out_data, 16'h0001);
    out_ready = 1'b1;
    wait_drain(60);
    wait_idle(20);

    // Stop mid-burst
    for (int i = 0; i < 8; i++) push_word(16'h2000 + 16'(i));
    snap_rd  = rd_total;
    snap_acc = acc_total;
    rd_en    = 1'b1;
    n = 0;
    while (rd_total - snap_rd < 2 && n < 20) begin
      tick();
      n++;
    end
    check("stop_reach2", rd_total - snap_rd, 2);
    rd_en = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("stop_busy_drop", busy, 0);
    check("stop_accepted", acc_total - snap_acc, 4);
    for (int i = 0; i < 10; i++) tick();
    check("stop_reads", rd_total - snap_rd, 4);
    check("stop_still_idle", busy, 0);
    rd_en = 1'b1;
    wait_drain(40);
    wait_idle(20);

    // Empty stall
    for (int i = 0; i < 3; i++) push_word(16'h3000 + 16'(i));
    snap_acc = acc_total;
    rd_en    = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("empty_busy", busy, 1);
    check("empty_acc3", acc_total - snap_acc, 3);
    check("empty_no_valid", out_valid, 0);
    push_word(16'h3003);
    wait_drain(20);
    wait_idle(20);

    // Async reset mid-burst
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'h4000 + 16'(i));
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_ = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_busy", busy, 0);
    check("async_read", fifo_read, 0);
    n = rd_total - acc_total;
    for (int i = 0; i < n; i++) void'(exp_q.pop_front());
    acc_total = rd_total;
    acc_cnt   = 0;
    push_word(16'h4004);
    push_word(16'h4005);
    tick();
    tick();
    rst_      = 1'b1;
    out_ready = 1'b1;
    wait_drain(40);
    wait_idle(20);

`ifdef FIFO_BURST_READER_STATS_EN
    // Stats
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr0", burst_count, 0);
    for (int i = 0; i < 12; i++) push_word(16'h5000 + 16'(i));
    rd_en = 1'b1;
    wait_drain(80);
    tick();
    check("stats_three", burst_count, 3);
    wait_idle(20);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_cleared", burst_count, 0);
`endif

    check("read_when_empty", rd_empty_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side controller for the team's synchronous FIFO.
- Drives fifo_read from fifo_empty and captures fifo_data_out one cycle after each read.
- Presents captured words on a valid/ready stream, grouped into fixed-length bursts with a last flag.
- Sits between the FIFO and any downstream consumer; decouples consumer back-pressure from FIFO read timing through a 2-entry output buffer.

Parameters:
- width, 16, data word width; must match the FIFO width.
- burst_len, 4, words per burst; legal range 1..256; out_last marks word burst_len-1 of each burst.

Ports:
- clk  input  1  system clock, rising edge.
- rst_  input  1  asynchronous active-low reset.
- rd_en  input  1  level; 1 = fetch bursts, 0 = stop at the next burst boundary.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  width  FIFO read data; valid the cycle after fifo_read=1.
- fifo_read  output  1  FIFO read strobe.
- out_valid  output  1  out_data/out_last valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- out_data  output  width  head-of-buffer word.
- out_last  output  1  head word is the last word of its burst.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset is asynchronous and active-low, on rst_.
- Reset values: fifo_read=0, out_valid=0, out_data=0, out_last=0, busy=0. Buffer occupancy=0, in-flight=0, burst count=0, FSM=IDLE.
- Read latency:
  - fifo_read=1 in cycle N; fifo_data_out is sampled at edge N+1 and written into the buffer tail.
  - A word is visible on out_data no earlier than cycle N+1.
- Credit rule:
  - fifo_read = active & !fifo_empty & (occupancy + inflight < 2), where inflight ∈ {0,1}.
  - A pop in the same cycle does not free a credit; the rule is a registered-occupancy check.
  - The FIFO is never read when empty, and the buffer never overflows.
- Buffer:
  - 2-entry FIFO of {data, last}.
  - Simultaneous push and pop is legal; occupancy is unchanged.
  - out_valid = occupancy != 0.
  - out_data/out_last are held stable while out_valid & !out_ready.
- Burst counter:
  - 8 bits; counts issued reads, wraps 0..burst_len-1.
  - The last tag is computed at issue time: last = (count == burst_len-1).
  - burst_len=1 sets last on every word.
- FSM:
  - IDLE: busy=0, no reads. rd_en=1 -> ACTIVE.
  - ACTIVE: issue reads per the credit rule.
    - rd_en=0 with count==0 (at a boundary) -> DRAIN.
    - rd_en=0 mid-burst -> STOPPING.
  - STOPPING: keep issuing reads until the read tagged last is issued, then -> DRAIN. Waits indefinitely if the FIFO is empty. rd_en returning to 1 -> ACTIVE.
  - DRAIN: no new reads; wait until inflight=0 and occupancy=0, then -> IDLE. rd_en=1 -> ACTIVE.
- Boundaries:
  - fifo_empty rising mid-burst stalls reads without ending the burst.
  - out_ready=0 for any duration stalls reads, with at most 2 words buffered.
  - Reset mid-burst discards buffered and in-flight words and restarts the count at 0.

Optional Feature:
- Macro: FIFO_BURST_READER_STATS_EN.
- When defined:
  - Extra output burst_count, 16 bits, reset 0.
  - Increments by 1 on each accepted word with out_last=1 (out_valid & out_ready & out_last); wraps at 65535 -> 0.
  - Extra input stats_clr, 1 bit; synchronous clear. Clear wins over a simultaneous increment.
- When undefined: no extra ports, no counter logic; all other behaviour is identical.

Test Plan:
- Single burst:
  - Stimulus: reset, FIFO preloaded with 0x0001..0x0004, rd_en=1, out_ready=1, burst_len=4.
  - Required: four words 0x0001..0x0004 in order; out_last=1 only on 0x0004; first fifo_read one cycle after rd_en is sampled; fifo_read never asserted with fifo_empty=1.
- Back-pressure:
  - Stimulus: 8 words in FIFO, out_ready=0 for 10 cycles, then 1.
  - Required: exactly 2 fifo_read pulses during the stall; out_data stable at 0x0001; after release, all 8 words in order; out_last on words 4 and 8.
- Stop mid-burst:
  - Stimulus: rd_en dropped after 2 words issued.
  - Required: reads continue to word 4 (last); busy stays 1 until word 4 is accepted; then busy=0 and no further fifo_read.
- Empty stall:
  - Stimulus: FIFO holds 3 words; 4th word written 20 cycles later.
  - Required: FSM stays ACTIVE; 4th word emitted with out_last=1.
- Async reset:
  - Stimulus: rst_=0 asserted mid-burst with 2 words buffered.
  - Required: out_valid=0 immediately, without waiting for a clock edge; after release, the next word carries count 0 (last only on the 4th).
- Stats:
  - Stimulus: FIFO_BURST_READER_STATS_EN defined, 3 full bursts, then stats_clr pulse.
  - Required: burst_count=3, then 0.
